req_grant_fetch_buffer: RTL and testbench
=========================================

// Module: req_grant_fetch_buffer
// PURPOSE
//  Requester side of a req/grant payload source. Raises req while buffer space exists.
//  Captures payload on every granted cycle into an in-order FIFO.
//  Presents entries downstream over valid/ready.
//  Sits directly upstream of the consumer; the provider answers req with a same-cycle grant+payload.
// PARAMETERS
//  payload_width     32   payload/FIFO data width (bits)
//  fifo_depth        4    FIFO entries; power of 2, >=2
//  stall_cnt_width   16   width of saturating stall counter
//  simulation_delay  1.0  register update delay (sim only)
// PORTS
//  clk          in   1                 clock; all logic on posedge
//  rst_n        in   1                 asynchronous, active-low reset
//  en           in   1                 fetch enable; req only while en=1
//  flush        in   1                 synchronous flush of FIFO contents
//  req          out  1                 request to provider
//  grant        in   1                 provider grant; valid only when req=1
//  payload      in   payload_width     provider data, sampled when req&grant
//  m_valid      out  1                 FIFO head valid
//  m_data       out  payload_width     FIFO head data
//  m_ready      in   1                 downstream accepts head
//  fifo_cnt     out  log2(depth)+1     current entry count
//  stall_cnt    out  stall_cnt_width   cycles with req=1 & grant=0 (saturating)
// BEHAVIOUR
//  Reset (async assert, sync release): req=0, m_valid=0, m_data=0, fifo_cnt=0,
//   stall_cnt=0; rd/wr pointers=0. req is registered; first req=1 is the cycle after the first
//   posedge with rst_n=1, en=1, flush=0.
//  req (registered), next value = en & ~flush & (cnt_next < fifo_depth).
//   cnt_next is the post-edge count. req has no combinational path from grant or m_ready.
//  push = req & grant & ~flush. payload is written at wr_ptr; wr_ptr++ (wraps mod depth).
//  pop = m_valid & m_ready & ~flush. rd_ptr++ (wraps mod depth).
//  m_valid = (fifo_cnt != 0). m_data = mem[rd_ptr].
//   Latency grant -> m_valid is 1 cycle when the FIFO is empty (no bypass).
//  push & pop in the same cycle: count unchanged, order preserved.
//  Full: req guaranteed 0, so grant is ignored. A grant with req=0 is a protocol violation;
//   assert in sim, no state change.
//  Empty: m_valid=0; m_ready is ignored.
//  flush=1: next edge sets ptrs=0, cnt=0, req=0. A grant in the flush cycle is discarded.
//   A pop in the flush cycle does not occur. req re-rises the cycle after flush deasserts
//   (if en=1).
//  en 1->0: req drops at next edge. A grant in the same cycle req was 1 is still accepted.
//  stall_cnt: +1 each cycle req=1 & grant=0, saturates at all-ones, never wraps.
//   Cleared only by reset (not by flush).
//  Reset mid-operation: all contents are lost immediately, outputs go to reset values.
// TESTING
//  1. Release reset, en=1, provider grants at once with 2000 -> req=1 from cycle 1;
//     m_valid=1, m_data=2000 the next cycle.
//  2. m_ready=0, grants 1984,1988,1992,1996 on back-to-back cycles -> fifo_cnt=4, req=0;
//     draining yields exactly that order, then req=1.
//  3. Provider holds grant low 3 cycles while req=1 -> stall_cnt += 3, req stays 1,
//     payload captured on the 4th cycle.
//  4. fifo_cnt=2, grant and m_ready in the same cycle -> fifo_cnt stays 2;
//     output order = old head, old 2nd, new entry.
//  5. flush=1 with grant=1 and 3 entries -> next cycle fifo_cnt=0, m_valid=0, req=0;
//     granted payload never appears.
//  6. Assert rst_n=0 mid-stream with 3 entries, pointers wrapped -> m_valid/req/fifo_cnt
//     drop to 0 before the next edge; refill after release starts at ptr 0.

Source files
------------

// File: rtl/req_grant_fetch_buffer.sv
// -----------------------------------------------------------------------------
// req_grant_fetch_buffer
//
// Requester side of a req/grant payload source. The block raises req whenever
// the FIFO will still have a free slot after the current edge. The provider
// answers req in the same cycle with grant and payload. Every granted payload
// is captured into an in-order FIFO. The FIFO head is presented downstream
// over a valid/ready handshake.
//
// Parameters
//   payload_width    payload and FIFO data width in bits
//   fifo_depth       number of FIFO entries; must be a power of two and >= 2
//   stall_cnt_width  width of the saturating stall counter
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   en         fetch enable; req is raised only while en=1
//   flush      synchronous flush; empties the FIFO and drops req
//   req        registered request to the provider
//   grant      provider grant; meaningful only while req=1
//   payload    provider data; captured when req & grant
//   m_valid    FIFO head valid
//   m_data     FIFO head data; zero while the FIFO is empty
//   m_ready    downstream accepts the head entry
//   fifo_cnt   current number of entries, 0..fifo_depth
//   stall_cnt  saturating count of cycles with req=1 and grant=0
// -----------------------------------------------------------------------------
module req_grant_fetch_buffer #(
  parameter int payload_width   = 32,
  parameter int fifo_depth      = 4,
  parameter int stall_cnt_width = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          flush,
  output logic                          req,
  input  logic                          grant,
  input  logic [payload_width-1:0]      payload,
  output logic                          m_valid,
  output logic [payload_width-1:0]      m_data,
  input  logic                          m_ready,
  output logic [$clog2(fifo_depth):0]   fifo_cnt,
  output logic [stall_cnt_width-1:0]    stall_cnt
);

  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = ptr_w + 1;

  localparam logic [cnt_w-1:0] cnt_one   = cnt_w'(1);
  localparam logic [cnt_w-1:0] cnt_full  = cnt_w'(fifo_depth);
  localparam logic [ptr_w-1:0] ptr_one   = ptr_w'(1);
  localparam logic [stall_cnt_width-1:0] stall_one = stall_cnt_width'(1);

  // ---------------------------------------------------------------------------
  // Storage and bookkeeping state
  // ---------------------------------------------------------------------------
  logic [payload_width-1:0] mem [fifo_depth];
  logic [ptr_w-1:0]         wr_ptr;
  logic [ptr_w-1:0]         rd_ptr;
  logic [cnt_w-1:0]         cnt;
  logic [cnt_w-1:0]         cnt_next;
  logic                     req_next;
  logic                     push;
  logic                     pop;

  // ---------------------------------------------------------------------------
  // Handshake qualification
  // ---------------------------------------------------------------------------
  // A grant only counts while req is high, so a stray grant while full (req=0)
  // cannot corrupt the FIFO. Flush discards both the grant and the pop of the
  // flush cycle.
  assign push = req & grant & ~flush;

  // m_valid gates m_ready, so a ready while empty is ignored.
  assign pop  = m_valid & m_ready & ~flush;

  // ---------------------------------------------------------------------------
  // Downstream view of the FIFO head
  // ---------------------------------------------------------------------------
  assign m_valid  = (cnt != '0);
  assign fifo_cnt = cnt;

  // The storage array is never reset, so the head is forced to zero while
  // empty; this keeps m_data at zero after reset and after a flush.
  assign m_data = m_valid ? mem[rd_ptr] : '0;

  // ---------------------------------------------------------------------------
  // Post-edge occupancy and the request decision
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal
    // unassigned; an unassigned path in always_comb infers a latch.
    cnt_next = cnt;
    if (flush) begin
      cnt_next = '0;
    end else if (push && !pop) begin
      cnt_next = cnt + cnt_one;
    end else if (pop && !push) begin
      cnt_next = cnt - cnt_one;
    end
  end

  // req is decided from the occupancy that will exist after this edge, so the
  // edge that fills the last slot also drops req. Because req is registered,
  // there is no combinational path from grant or m_ready to req.
  assign req_next = en & ~flush & (cnt_next < cnt_full);

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      req    <= 1'b0;
    end else begin
      cnt <= cnt_next;
      req <= req_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        // Pointer widths equal log2(depth), so the natural roll-over is the
        // modulo-depth wrap.
        if (push) wr_ptr <= wr_ptr + ptr_one;
        if (pop)  rd_ptr <= rd_ptr + ptr_one;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Payload storage
  // ---------------------------------------------------------------------------
  // NOTE: the data array has no reset. Its contents are only observable
  // through entries counted in cnt, and cnt is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= payload;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating stall counter
  // ---------------------------------------------------------------------------
  // Counts every cycle the provider leaves an outstanding request unanswered.
  // It holds at all-ones instead of wrapping. Flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (req && !grant && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + stall_one;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol check (simulation)
  // ---------------------------------------------------------------------------
  // The provider may only grant an outstanding request. The push qualifier
  // already ignores such a grant; this flags the provider bug.
  grant_needs_req: assert property (@(posedge clk) disable iff (!rst_n) grant |-> req);

endmodule

// File: tb/tb_req_grant_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_req_grant_fetch_buffer
//
// Directed scenarios followed by a randomized phase. Expected values come from
// a queue-based reference model: the FIFO is a queue of payloads, the count is
// its size, and req follows the enable/flush/room rule after each edge.
// Inputs change 1 time unit after the rising edge. Outputs are sampled at
// that same point, before any new input is driven.
// -----------------------------------------------------------------------------
module tb_req_grant_fetch_buffer;

  localparam int PW        = 32;
  localparam int DEPTH     = 4;
  localparam int SW        = 5;            // narrow so saturation is reachable
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int STALL_MAX = (1 << SW) - 1;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          en      = 1'b0;
  logic          flush   = 1'b0;
  logic          grant   = 1'b0;
  logic          m_ready = 1'b0;
  logic [PW-1:0] payload = '0;
  logic          req;
  logic          m_valid;
  logic [PW-1:0] m_data;
  logic [CW-1:0] fifo_cnt;
  logic [SW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [PW-1:0] q[$];
  bit            m_req;
  int            m_stall;

  req_grant_fetch_buffer #(
    .payload_width  (PW),
    .fifo_depth     (DEPTH),
    .stall_cnt_width(SW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .flush    (flush),
    .req      (req),
    .grant    (grant),
    .payload  (payload),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .fifo_cnt (fifo_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_req   = 1'b0;
    m_stall = 0;
  endtask

  // Advance one clock. The model applies the inputs that were stable at this
  // edge. Control then returns 1 time unit after the edge.
  task automatic cycle();
    bit do_push;
    bit do_pop;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      do_push = m_req && grant && !flush;
      do_pop  = (q.size() != 0) && m_ready && !flush;
      if (m_req && !grant && m_stall < STALL_MAX) m_stall++;
      if (flush) begin
        q.delete();
      end else begin
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(payload);
      end
      m_req = en && !flush && (q.size() < DEPTH);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", req); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
    n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %0d want 0", m_data); end
    n_checks++; if (fifo_cnt !== '0) begin n_fail++; $display("FAIL reset_fifo_cnt: got %0d want 0", fifo_cnt); end
    n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_first_fetch();
    rst_n   = 1'b1;
    en      = 1'b1;
    m_ready = 1'b0;
    cycle();
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %0b want 1", req); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL first_no_bypass: got %0b want 0", m_valid); end
    grant   = 1'b1;
    payload = 32'd2000;
    cycle();
    grant   = 1'b0;
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL first_m_valid: got %0b want 1", m_valid); end
    n_checks++; if (m_data !== 32'd2000) begin n_fail++; $display("FAIL first_m_data: got %0d want 2000", m_data); end
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
    n_checks++; if (fifo_cnt !== CW'(0)) begin n_fail++; $display("FAIL first_drain_cnt: got %0d want 0", fifo_cnt); end
  endtask

  task automatic test_fill_drain();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      grant   = 1'b1;
      payload = PW'(1984 + 4 * i);
      cycle();
    end
    grant = 1'b0;
    n_checks++; if (fifo_cnt !== CW'(4)) begin n_fail++; $display("FAIL full_cnt: got %0d want 4", fifo_cnt); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL full_req: got %0b want 0", req); end
    cycle();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL full_req_hold: got %0b want 0", req); end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (m_data !== PW'(1984 + 4 * i)) begin
        n_fail++; $display("FAIL drain_order_%0d: got %0d want %0d", i, m_data, 1984 + 4 * i);
      end
      cycle();
    end
    m_ready = 1'b0;
    n_checks++; if (fifo_cnt !== CW'(0)) begin n_fail++; $display("FAIL drain_cnt: got %0d want 0", fifo_cnt); end
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL drain_req: got %0b want 1", req); end
  endtask

  task automatic test_stall();
    int            base;
    int            want;
    logic [PW-1:0] word;
    base  = m_stall;
    grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL stall_req_%0d: got %0b want 1", i, req); end
    end
    want = (base + 3 > STALL_MAX) ? STALL_MAX : base + 3;
    n_checks++; if (stall_cnt !== SW'(want)) begin n_fail++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, want); end
    word    = $urandom;
    grant   = 1'b1;
    payload = word;
    cycle();
    grant = 1'b0;
    n_checks++; if (stall_cnt !== SW'(want)) begin n_fail++; $display("FAIL stall_hold: got %0d want %0d", stall_cnt, want); end
    n_checks++; if (m_data !== word) begin n_fail++; $display("FAIL stall_capture: got %0h want %0h", m_data, word); end
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [PW-1:0] a;
    logic [PW-1:0] b;
    logic [PW-1:0] c;
    a = $urandom; b = $urandom; c = $urandom;
    grant = 1'b1;
    payload = a; cycle();
    payload = b; cycle();
    n_checks++; if (fifo_cnt !== CW'(2)) begin n_fail++; $display("FAIL pp_setup_cnt: got %0d want 2", fifo_cnt); end
    payload = c;
    m_ready = 1'b1;
    n_checks++; if (m_data !== a) begin n_fail++; $display("FAIL pp_head_a: got %0h want %0h", m_data, a); end
    cycle();
    grant = 1'b0;
    n_checks++; if (fifo_cnt !== CW'(2)) begin n_fail++; $display("FAIL pp_cnt: got %0d want 2", fifo_cnt); end
    n_checks++; if (m_data !== b) begin n_fail++; $display("FAIL pp_head_b: got %0h want %0h", m_data, b); end
    cycle();
    n_checks++; if (m_data !== c) begin n_fail++; $display("FAIL pp_head_c: got %0h want %0h", m_data, c); end
    cycle();
    m_ready = 1'b0;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL pp_empty: got %0b want 0", m_valid); end
  endtask

  task automatic test_flush();
    logic [PW-1:0] lost;
    logic [PW-1:0] fresh;
    lost  = 32'hDEAD_0000 | PW'($urandom_range(0, 255));
    fresh = 32'h0000_BEEF;
    grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      payload = $urandom;
      cycle();
    end
    n_checks++; if (fifo_cnt !== CW'(3)) begin n_fail++; $display("FAIL flush_setup_cnt: got %0d want 3", fifo_cnt); end
    flush   = 1'b1;
    payload = lost;
    m_ready = 1'b1;
    cycle();
    flush   = 1'b0;
    grant   = 1'b0;
    m_ready = 1'b0;
    n_checks++; if (fifo_cnt !== CW'(0)) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", fifo_cnt); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_m_valid: got %0b want 0", m_valid); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL flush_req: got %0b want 0", req); end
    cycle();
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL flush_req_rise: got %0b want 1", req); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_lost_seen: got %0b want 0", m_valid); end
    grant   = 1'b1;
    payload = fresh;
    cycle();
    grant = 1'b0;
    n_checks++; if (m_data !== fresh) begin n_fail++; $display("FAIL flush_refill: got %0h want %0h", m_data, fresh); end
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] z0;
    logic [PW-1:0] z1;
    // Stream through the FIFO so both pointers wrap, then leave 3 entries.
    grant   = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      payload = $urandom;
      cycle();
    end
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      payload = $urandom;
      cycle();
    end
    grant = 1'b0;
    n_checks++; if (fifo_cnt !== CW'(3)) begin n_fail++; $display("FAIL rst_mid_setup_cnt: got %0d want 3", fifo_cnt); end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_m_valid: got %0b want 0", m_valid); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %0b want 0", req); end
    n_checks++; if (fifo_cnt !== CW'(0)) begin n_fail++; $display("FAIL rst_mid_cnt: got %0d want 0", fifo_cnt); end
    n_checks++; if (stall_cnt !== SW'(0)) begin n_fail++; $display("FAIL rst_mid_stall: got %0d want 0", stall_cnt); end
    cycle();
    rst_n = 1'b1;
    cycle();
    z0 = $urandom; z1 = $urandom;
    grant = 1'b1;
    payload = z0; cycle();
    payload = z1; cycle();
    grant = 1'b0;
    n_checks++; if (fifo_cnt !== CW'(2)) begin n_fail++; $display("FAIL refill_cnt: got %0d want 2", fifo_cnt); end
    n_checks++; if (m_data !== z0) begin n_fail++; $display("FAIL refill_head: got %0h want %0h", m_data, z0); end
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
    n_checks++; if (m_data !== z1) begin n_fail++; $display("FAIL refill_second: got %0h want %0h", m_data, z1); end
  endtask

  task automatic test_random();
    logic [PW-1:0] want_data;
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      m_ready = $urandom_range(0, 1);
      grant   = m_req ? 1'($urandom_range(0, 1)) : 1'b0;
      payload = $urandom;
      cycle();
      want_data = (q.size() != 0) ? q[0] : '0;
      n_checks++; if (req !== m_req) begin n_fail++; $display("FAIL rand_req@%0d: got %0b want %0b", i, req, m_req); end
      n_checks++; if (fifo_cnt !== CW'(q.size())) begin n_fail++; $display("FAIL rand_cnt@%0d: got %0d want %0d", i, fifo_cnt, q.size()); end
      n_checks++; if (m_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_m_valid@%0d: got %0b want %0b", i, m_valid, q.size() != 0); end
      n_checks++; if (m_data !== want_data) begin n_fail++; $display("FAIL rand_m_data@%0d: got %0h want %0h", i, m_data, want_data); end
      n_checks++; if (stall_cnt !== SW'(m_stall)) begin n_fail++; $display("FAIL rand_stall@%0d: got %0d want %0d", i, stall_cnt, m_stall); end
    end
    en = 1'b0; flush = 1'b0; grant = 1'b0; m_ready = 1'b0;
    // The counter has saturated by now; it must hold at all-ones.
    n_checks++; if (m_stall == STALL_MAX && stall_cnt !== SW'(STALL_MAX)) begin n_fail++; $display("FAIL stall_saturate: got %0d want %0d", stall_cnt, STALL_MAX); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_fetch();
    test_fill_drain();
    test_stall();
    test_push_pop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
